forth_stack_core: RTL and testbench



---
 rtl/forth_pkg.sv | 26 ++
 rtl/forth_stack_core_if.sv | 27 ++
 rtl/forth_lifo.sv | 66 ++++++
 rtl/forth_stack_core.sv | 83 ++++++++
 tb/tb_forth_stack_core.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/forth_pkg.sv
// Shared encodings for the Forth datapath core: commands, ALU operators, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package forth_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_PUSH = 4'd1,
    CMD_POP  = 4'd2,
    CMD_ADD  = 4'd3,
    CMD_MUL  = 4'd4,
    CMD_DUP  = 4'd5,
    CMD_SUB  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_RSV = 2'b11
  } op_e;

endpackage

// File: rtl/forth_stack_core_if.sv
// Command/data bus between the sequencer (master) and the stack core (slave).
// Latency: n/a (wires only).
// Backpressure: none; one command per cycle, every cycle.
interface forth_stack_core_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       command;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] result;
  logic             write;
  logic             read;
  logic [1:0]       operator;
  logic             empty;
  logic             full;

  modport master (
    output command, data_in,
    input  top, next, result, write, read, operator, empty, full
  );

  modport slave (
    input  command, data_in,
    output top, next, result, write, read, operator, empty, full
  );
endinterface

// File: rtl/forth_lifo.sv
// LIFO data stack: storage array, pointer and occupancy flags with top/next read ports.
// Latency: push/pop visible on top/next/flags one cycle after the strobe is sampled.
// Backpressure: none; push when full and pop when empty are silently dropped.
module forth_lifo
  import forth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] next_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic [AW-1:0]    top_idx, next_idx;
  logic             do_push, do_pop;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Index arithmetic wraps in AW bits, so sp==DEPTH still addresses DEPTH-1.
  assign top_idx  = sp_q[AW-1:0] - AW'(1);
  assign next_idx = sp_q[AW-1:0] - AW'(2);

  assign top_o  = (sp_q >= SW'(1)) ? mem_q[top_idx]  : '0;
  assign next_o = (sp_q >= SW'(2)) ? mem_q[next_idx] : '0;

  // Next stack pointer from the gated push/pop strobes.
  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SW'(1);
    end
  end

  // Pointer register; reset empties the stack regardless of command.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage write; contents are left alone by reset since sp hides them.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[sp_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/forth_stack_core.sv
// Forth datapath core: command decoder, combinational ALU and LIFO stack (optional SUB via FORTH_ALU_SUB_EN).
// Latency: decode and result are combinational; stack changes visible after the next rising edge.
// Backpressure: none; a command is consumed every cycle, invalid pushes/pops are ignored.
module forth_stack_core
  import forth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  forth_stack_core_if.slave   bus
);
  logic             dec_write, dec_read, dec_dup;
  logic [1:0]       dec_op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] stk_top, stk_next;
  logic [WIDTH-1:0] push_dat;
  logic             stk_empty, stk_full;

  // Command decode into stack strobes and ALU operator.
  always_comb begin
    dec_write = 1'b0;
    dec_read  = 1'b0;
    dec_dup   = 1'b0;
    dec_op    = OP_ADD;
    case (cmd_e'(bus.command))
      CMD_PUSH: dec_write = 1'b1;
      CMD_DUP: begin
        dec_write = 1'b1;
        dec_dup   = 1'b1;
      end
      CMD_POP:  dec_read = 1'b1;
      CMD_ADD:  dec_op   = OP_ADD;
      CMD_MUL:  dec_op   = OP_MUL;
`ifdef FORTH_ALU_SUB_EN
      CMD_SUB:  dec_op   = OP_SUB;
`endif
      default: ;
    endcase
  end

  // ALU on the two top entries; reserved operator yields zero.
  always_comb begin
    alu_res = '0;
    case (op_e'(dec_op))
      OP_ADD: alu_res = stk_top + stk_next;
      OP_MUL: alu_res = stk_top * stk_next;
`ifdef FORTH_ALU_SUB_EN
      OP_SUB: alu_res = stk_next - stk_top;
`endif
      default: alu_res = '0;
    endcase
  end

  // DUP re-pushes the current top, which reads as zero on an empty stack.
  assign push_dat = dec_dup ? stk_top : bus.data_in;

  forth_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (dec_write),
    .pop_i      (dec_read),
    .push_dat_i (push_dat),
    .top_o      (stk_top),
    .next_o     (stk_next),
    .empty_o    (stk_empty),
    .full_o     (stk_full)
  );

  assign bus.top      = stk_top;
  assign bus.next     = stk_next;
  assign bus.result   = alu_res;
  assign bus.write    = dec_write;
  assign bus.read     = dec_read;
  assign bus.operator = dec_op;
  assign bus.empty    = stk_empty;
  assign bus.full     = stk_full;

endmodule

// File: tb/tb_forth_stack_core.sv
// Self-checking bench for forth_stack_core with a reference stack model and state scoreboard.
// Latency: state expectations are checked one cycle after the command; decode/result in the same cycle.
// Backpressure: none.
module tb_forth_stack_core;
  localparam int W = 16;
  localparam int D = 16;

  typedef struct {
    logic [W-1:0] top;
    logic [W-1:0] nxt;
    logic         empty;
    logic         full;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forth_stack_core_if #(.WIDTH(W)) bus ();

  forth_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mstk[$];
  bit           model_valid = 1'b0;
  st_t          exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (mstk.size() >= 1) ? mstk[mstk.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_next();
    return (mstk.size() >= 2) ? mstk[mstk.size()-2] : '0;
  endfunction

  // One clock cycle: check the state expected from the previous command,
  // drive the new one, check combinational outputs, then advance the model.
  task automatic step(input logic r, input logic [3:0] c, input logic [W-1:0] d, input string tag);
    st_t          e;
    logic         ew, er;
    logic [1:0]   eop;
    logic [W-1:0] a, b, eres;
    logic [W-1:0] prod;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".top"},   32'(bus.top),   32'(e.top));
      chk({tag, ".next"},  32'(bus.next),  32'(e.nxt));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(e.empty));
      chk({tag, ".full"},  32'(bus.full),  32'(e.full));
    end
    rst = r;
    bus.command = c;
    bus.data_in = d;
    #1;
    ew  = (c == 4'd1) || (c == 4'd5);
    er  = (c == 4'd2);
    eop = 2'b00;
    if (c == 4'd4) eop = 2'b01;
`ifdef FORTH_ALU_SUB_EN
    if (c == 4'd6) eop = 2'b10;
`endif
    chk({tag, ".write"},    32'(bus.write),    32'(ew));
    chk({tag, ".read"},     32'(bus.read),     32'(er));
    chk({tag, ".operator"}, 32'(bus.operator), 32'(eop));
    if (model_valid) begin
      a = m_top();
      b = m_next();
      prod = a * b;
      case (eop)
        2'b00:   eres = a + b;
        2'b01:   eres = prod;
        2'b10:   eres = b - a;
        default: eres = '0;
      endcase
      chk({tag, ".result"}, 32'(bus.result), 32'(eres));
    end
    if (r) begin
      mstk.delete();
      model_valid = 1'b1;
    end else if (c == 4'd1) begin
      if (mstk.size() < D) mstk.push_back(d);
    end else if (c == 4'd5) begin
      if (mstk.size() < D) mstk.push_back(m_top());
    end else if (c == 4'd2) begin
      if (mstk.size() > 0) void'(mstk.pop_back());
    end
    e.top   = m_top();
    e.nxt   = m_next();
    e.empty = (mstk.size() == 0);
    e.full  = (mstk.size() == D);
    exp_q.push_back(e);
  endtask

  initial begin
    bus.command = 4'd0;
    bus.data_in = '0;

    // Reset, then push/pop basics.
    step(1, 4'd0, 16'h0, "rst");
    step(0, 4'd0, 16'h0, "idle");
    step(0, 4'd1, 16'd11, "push11");
    step(0, 4'd1, 16'd13, "push13");
    step(0, 4'd2, 16'h0, "pop1");
    step(0, 4'd2, 16'h0, "pop2");

    // MUL / ADD non-destructive, then DUP.
    step(0, 4'd1, 16'd7, "push7");
    step(0, 4'd1, 16'd2, "push2");
    step(0, 4'd4, 16'h0, "mul");
    step(0, 4'd3, 16'h0, "add");
    step(0, 4'd5, 16'h0, "dup");
    step(0, 4'd0, 16'h0, "after_dup");

    // Command 6 with 7 under 2 on top.
    step(1, 4'd0, 16'h0, "rst2");
    step(0, 4'd1, 16'd7, "s_push7");
    step(0, 4'd1, 16'd2, "s_push2");
    step(0, 4'd6, 16'h1234, "cmd6");
    step(0, 4'd0, 16'h0, "after6");

    // Undefined commands behave as NOP.
    for (int k = 7; k < 16; k++) step(0, 4'(k), 16'hBEEF, "undef");

    // Overflow: DEPTH+1 pushes, last one dropped; DUP on full dropped too.
    step(1, 4'd0, 16'h0, "rst3");
    for (int k = 0; k <= D; k++) step(0, 4'd1, 16'(k + 1), "fill");
    step(0, 4'd5, 16'h0, "dup_full");
    // Drain and underflow.
    for (int k = 0; k < D; k++) step(0, 4'd2, 16'h0, "drain");
    step(0, 4'd2, 16'h0, "pop_empty");
    step(0, 4'd5, 16'h0, "dup_empty");
    step(0, 4'd2, 16'h0, "pop_dup0");

    // Wrap-around arithmetic.
    step(0, 4'd1, 16'hFFFF, "push_ffff");
    step(0, 4'd1, 16'd2, "w_push2");
    step(0, 4'd3, 16'h0, "w_add");
    step(0, 4'd4, 16'h0, "w_mul");

    // Reset while a PUSH is presented.
    step(1, 4'd1, 16'd5, "rst_push5");
    step(0, 4'd0, 16'h0, "post_rst");
    step(0, 4'd1, 16'hA5A5, "push_a5");
    step(0, 4'd0, 16'h0, "drain_q");

    // Random traffic against the model.
    for (int k = 0; k < 200; k++) begin
      step(0, 4'($urandom_range(0, 15)), 16'($urandom), "rand");
    end
    step(0, 4'd0, 16'h0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop guard in case the clock or stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
